// File: rtl/and_ex_pkg.sv
// Shared types and helpers for the and_gate exerciser.
package and_ex_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        FIN
    } state_e;

    localparam int N_PATTERNS = 4;

    typedef struct packed {
        logic a;
        logic b;
    } pat_t;

    // Pattern index bit 1 drives in_a, bit 0 drives in_b.
    function automatic pat_t pattern_to_inputs(input logic [1:0] idx);
        pat_t p;
        p.a = idx[1];
        p.b = idx[0];
        return p;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; expire flags terminal count and the counter
// reloads itself when decremented while expired.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = (cnt_q == '0);

    // Next count: explicit load wins, otherwise count down with auto-reload.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = expire_o ? load_val_i : cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/and_gate_exerciser.sv
// Sweeps the and_gate inputs through 00,01,10,11 and counts response errors.
//
// state | meaning
// IDLE  | waiting for start, gate inputs held at 0
// DRIVE | sweeping patterns, sampling out_sum on the last hold cycle
// FIN   | one-cycle done pulse, pass result latched
module and_gate_exerciser
    import and_ex_pkg::*;
#(
    parameter int HOLD_CYCLES = 5,
    parameter int LOOPS       = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_a,
    output logic             in_b,
    input  logic             out_sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LOOP_LOAD = LW'(LOOPS - 1);
    localparam logic [1:0]    LAST_IDX  = 2'(N_PATTERNS - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             in_a_q, in_b_q;
    pat_t             pat_d;

    logic timer_load;
    logic hold_dec;
    logic hold_expire;
    logic loop_dec;
    logic loop_expire;
    logic mismatch;

    hold_timer #(.W(HW)) u_hold_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .dec_i      (hold_dec),
        .load_val_i (HOLD_LOAD),
        .expire_o   (hold_expire)
    );

    hold_timer #(.W(LW)) u_loop_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .dec_i      (loop_dec),
        .load_val_i (LOOP_LOAD),
        .expire_o   (loop_expire)
    );

    // The registered inputs are what the gate sees this cycle.
    assign mismatch = (out_sum != (in_a_q & in_b_q));

    // Next-state, pattern advance, error counting and result capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_cnt_d  = err_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        timer_load = 1'b0;
        hold_dec   = 1'b0;
        loop_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    idx_d      = 2'd0;
                    err_cnt_d  = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                end
            end
            DRIVE: begin
                hold_dec = 1'b1;
                if (hold_expire) begin
                    if (mismatch && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        loop_dec = 1'b1;
                        if (loop_expire) begin
                            state_d = FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            // Includes a mismatch found on this final sample.
                            pass_d  = (err_cnt_d == '0);
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pat_d = '0;
        if (state_d == DRIVE) begin
            pat_d = pattern_to_inputs(idx_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            in_a_q    <= 1'b0;
            in_b_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            in_a_q    <= pat_d.a;
            in_b_q    <= pat_d.b;
        end
    end

    assign in_a    = in_a_q;
    assign in_b    = in_b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;

endmodule
